seq_factorial: RTL and testbench

//  Iterative, parametrised factorial unit: computes n! for an IN_W-bit operand

---
 rtl/seq_factorial_if.sv | 16 +
 rtl/seq_factorial.sv | 84 ++++++++
 tb/tb_seq_factorial.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_factorial_if.sv
// Handshake bundle for the iterative factorial unit: start/operand in,
// busy/done/result/overflow out.
interface seq_factorial_if #(
  parameter int WIDTH = 6,
  parameter int IN_W  = 6
);
  logic             start;
  logic [IN_W-1:0]  n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (output start, n, input busy, done, result, overflow);
  modport slave  (input start, n, output busy, done, result, overflow);
endinterface

// File: rtl/seq_factorial.sv
// Iterative n! unit: one multiply per clock, early exit on overflow,
// start/busy/done handshake with registered result and overflow flag.
module seq_factorial #(
  parameter int WIDTH    = 6,
  parameter int IN_W     = 6,
  parameter int SATURATE = 0
) (
  input logic           clk,
  input logic           rst_n,
  seq_factorial_if.slave bus
);
  localparam int PW = WIDTH + IN_W + 1;
  localparam int CW = IN_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [IN_W-1:0]  n_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic [PW-1:0]    prod;
  logic             finish;

  // Full-width product so any bit above WIDTH flags overflow.
  assign prod   = {{CW{1'b0}}, acc} * {{WIDTH{1'b0}}, cnt};
  assign finish = (cnt > {1'b0, n_q}) || ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      n_q        <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            n_q    <= bus.n;
            acc    <= {{(WIDTH-1){1'b0}}, 1'b1};
            cnt    <= CW'(2);
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (finish) begin
            result_q   <= (ovf_q && (SATURATE != 0)) ? {WIDTH{1'b1}} : acc;
            overflow_q <= ovf_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= DONE;
          end else begin
            acc   <= prod[WIDTH-1:0];
            ovf_q <= ovf_q | (|prod[PW-1:WIDTH]);
            cnt   <= cnt + CW'(1);
          end
        end
        DONE: begin
          // Start is deliberately not sampled here; the next run begins from IDLE.
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_seq_factorial.sv
// Scoreboard bench: three factorial instances (6/6 truncating, 6/6 saturating,
// 16/4 truncating) driven with directed and random operands.
module tb_seq_factorial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_factorial_if #(.WIDTH(6),  .IN_W(6)) ia ();
  seq_factorial_if #(.WIDTH(6),  .IN_W(6)) ib ();
  seq_factorial_if #(.WIDTH(16), .IN_W(4)) ic ();

  seq_factorial #(.WIDTH(6),  .IN_W(6), .SATURATE(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  seq_factorial #(.WIDTH(6),  .IN_W(6), .SATURATE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  seq_factorial #(.WIDTH(16), .IN_W(4), .SATURATE(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  logic        start_s [3];
  logic [7:0]  n_s     [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [15:0] res_s   [3];
  logic        ovf_s   [3];

  assign ia.start = start_s[0]; assign ia.n = n_s[0][5:0];
  assign ib.start = start_s[1]; assign ib.n = n_s[1][5:0];
  assign ic.start = start_s[2]; assign ic.n = n_s[2][3:0];
  assign busy_s[0] = ia.busy; assign done_s[0] = ia.done;
  assign res_s[0] = {10'd0, ia.result}; assign ovf_s[0] = ia.overflow;
  assign busy_s[1] = ib.busy; assign done_s[1] = ib.done;
  assign res_s[1] = {10'd0, ib.result}; assign ovf_s[1] = ib.overflow;
  assign busy_s[2] = ic.busy; assign done_s[2] = ic.done;
  assign res_s[2] = ic.result; assign ovf_s[2] = ic.overflow;

  typedef struct {
    int     nv;
    int     res;
    bit     ovf;
    int     lat;
    longint acc_cyc;
  } exp_t;

  exp_t   qa[$], qb[$], qc[$];
  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  int     last_res [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lane_w(input int l);
    return (l == 2) ? 16 : 6;
  endfunction

  // Reference: exact n! with a stop at the first multiplier that exceeds the range.
  function automatic void model(input int nv, input int w, input bit sat,
                                output int res, output bit ovf, output int lat);
    longint full = 1;
    longint maxv = (64'd1 << w) - 1;
    ovf = 1'b0;
    lat = (nv < 1) ? 1 : nv;
    for (int k = 2; k <= nv; k++) begin
      full = full * k;
      if (full > maxv) begin
        ovf = 1'b1;
        lat = k;
        break;
      end
    end
    if (ovf) res = sat ? int'(maxv) : int'(full & maxv);
    else     res = int'(full);
  endfunction

  function automatic void push_exp(input int l, input exp_t e);
    case (l)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endfunction

  function automatic void pop_exp(input int l, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{0, 0, 1'b0, 0, 0};
    case (l)
      0: if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); ok = 1'b1; end
    endcase
  endfunction

  // Called at a negedge; waits for idle (optionally pulsing ignored starts while busy),
  // then presents one start and records the expected response.
  task automatic issue(input int l, input int nv, input bit spur);
    int   guard = 0;
    exp_t e;
    while ((busy_s[l] || done_s[l]) && guard < 500) begin
      start_s[l] = spur && busy_s[l] && !done_s[l] && ($urandom_range(0, 2) == 0);
      n_s[l]     = 8'($urandom);
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL lane%0d idle_wait: busy=%0b required 0 within 500 cycles", l, busy_s[l]);
    end else begin
      start_s[l] = 1'b1;
      n_s[l]     = 8'(nv);
      e.nv       = nv;
      model(nv, lane_w(l), l == 1, e.res, e.ovf, e.lat);
      e.acc_cyc  = cyc + 1;
      push_exp(l, e);
      @(negedge clk);
      start_s[l] = 1'b0;
      n_s[l]     = 8'($urandom);
    end
  endtask

  // Monitor: pops on every done pulse, and watches that result holds between pulses.
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      exp_t e;
      bit   ok;
      if (!rst_n) begin
        last_res[l] = 0;
      end else if (done_s[l]) begin
        pop_exp(l, e, ok);
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL lane%0d unexpected_done: result=%0d with no run outstanding", l, res_s[l]);
        end else if (int'(res_s[l]) != e.res || ovf_s[l] != e.ovf ||
                     (cyc - e.acc_cyc) != longint'(e.lat) || busy_s[l]) begin
          miscompares++;
          $display("FAIL lane%0d n=%0d: result=%0d ovf=%0b lat=%0d busy=%0b, required result=%0d ovf=%0b lat=%0d busy=0",
                   l, e.nv, res_s[l], ovf_s[l], cyc - e.acc_cyc, busy_s[l], e.res, e.ovf, e.lat);
        end else begin
          $display("lane%0d n=%0d result=%0d ovf=%0b lat=%0d ok", l, e.nv, res_s[l], ovf_s[l], e.lat);
        end
        last_res[l] = int'(res_s[l]);
      end else if (int'(res_s[l]) != last_res[l]) begin
        miscompares++;
        $display("FAIL lane%0d result_hold: result=%0d required %0d between runs", l, res_s[l], last_res[l]);
      end
    end
  end

  task automatic check_zero(input int l, input string tag);
    vectors++;
    if (busy_s[l] || done_s[l] || res_s[l] != 16'd0 || ovf_s[l]) begin
      miscompares++;
      $display("FAIL lane%0d %s: busy=%0b done=%0b result=%0d ovf=%0b required all 0",
               l, tag, busy_s[l], done_s[l], res_s[l], ovf_s[l]);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((qa.size() + qb.size() + qc.size()) > 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    if (guard >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d runs outstanding, required 0", qa.size() + qb.size() + qc.size());
    end
  endtask

  initial begin
    for (int l = 0; l < 3; l++) begin
      start_s[l] = 1'b0;
      n_s[l]     = 8'd0;
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < 3; l++) check_zero(l, "reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    fork
      begin
        int dir_a [5] = '{0, 1, 4, 5, 63};
        foreach (dir_a[i]) issue(0, dir_a[i], 1'b1);
        repeat (40) issue(0, int'($urandom_range(0, 63)), 1'b1);
      end
      begin
        int dir_b [3] = '{5, 63, 3};
        foreach (dir_b[i]) issue(1, dir_b[i], 1'b0);
        repeat (15) issue(1, int'($urandom_range(0, 63)), 1'b1);
      end
      begin
        int dir_c [4] = '{8, 9, 15, 0};
        foreach (dir_c[i]) issue(2, dir_c[i], 1'b0);
        repeat (15) issue(2, int'($urandom_range(0, 15)), 1'b1);
      end
    join
    drain();

    // Abort a run of n=4 two cycles after acceptance, then rerun it.
    start_s[0] = 1'b1;
    n_s[0]     = 8'd4;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (!busy_s[0]) begin
      miscompares++;
      $display("FAIL lane0 midrun_busy: busy=%0b required 1", busy_s[0]);
    end
    #2 rst_n = 1'b0;
    #1 check_zero(0, "async_abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero(0, "after_abort");
    issue(0, 4, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
